// File: rtl/mem_stage_pkg.sv
// Shared types and ISA constants for the rv32 memory-access stage.
// Holds the EX/MEM and MEM/WB pipeline bundles plus the load/store funct3 encodings.
package mem_stage_pkg;
   localparam int XLEN = 32;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] alu_result;
      logic [XLEN-1:0] rs2_data;
      logic [4:0]      rd;
      logic            reg_write;
      logic            mem_read;
      logic            mem_write;
      logic [2:0]      funct3;
   } ex_mem_t;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [4:0]      rd;
      logic            reg_write;
      logic [XLEN-1:0] wb_data;
      logic            fault;
   } mem_wb_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } mem_state_e;
endpackage

// File: rtl/mem_align.sv
// Combinational access checker and lane steering: decides legality of a load/store,
// builds store lanes and byte enables, and extracts/extends load data from a read word.
module mem_align
   import mem_stage_pkg::*;
(
   input  logic            is_load_i,
   input  logic            is_store_i,
   input  logic [2:0]      funct3_i,
   input  logic [1:0]      off_i,
   input  logic [XLEN-1:0] st_data_i,
   output logic            legal_o,
   output logic [XLEN-1:0] st_wdata_o,
   output logic [3:0]      be_o,
   input  logic [2:0]      ld_funct3_i,
   input  logic [1:0]      ld_off_i,
   input  logic [XLEN-1:0] rdata_i,
   output logic [XLEN-1:0] ld_data_o
);
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      legal_o    = 1'b0;
      st_wdata_o = st_data_i;
      be_o       = 4'b1111;
      if (is_store_i) begin
         case (funct3_i)
            F3_SB: begin
               legal_o    = 1'b1;
               st_wdata_o = {4{st_data_i[7:0]}};
               be_o       = 4'b0001 << off_i;
            end
            F3_SH: begin
               legal_o    = ~off_i[0];
               st_wdata_o = {2{st_data_i[15:0]}};
               be_o       = off_i[1] ? 4'b1100 : 4'b0011;
            end
            F3_SW:   legal_o = (off_i == 2'b00);
            default: legal_o = 1'b0;
         endcase
      end else if (is_load_i) begin
         case (funct3_i)
            F3_LB, F3_LBU: legal_o = 1'b1;
            F3_LH, F3_LHU: legal_o = ~off_i[0];
            F3_LW:         legal_o = (off_i == 2'b00);
            default:       legal_o = 1'b0;
         endcase
      end
   end

   always_comb begin
      case (ld_off_i)
         2'd0:    byte_sel = rdata_i[7:0];
         2'd1:    byte_sel = rdata_i[15:8];
         2'd2:    byte_sel = rdata_i[23:16];
         default: byte_sel = rdata_i[31:24];
      endcase
      half_sel = ld_off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
      case (ld_funct3_i)
         F3_LB:   ld_data_o = {{24{byte_sel[7]}}, byte_sel};
         F3_LBU:  ld_data_o = {24'd0, byte_sel};
         F3_LH:   ld_data_o = {{16{half_sel[15]}}, half_sel};
         F3_LHU:  ld_data_o = {16'd0, half_sel};
         default: ld_data_o = rdata_i;
      endcase
   end
endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: issues one aligned req/ack data transaction per memory op and
// produces the registered MEM/WB bundle, holding upstream while a transaction is in flight.
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic            iClk,
   input  logic            nRst,
   input  logic            iEn,
   input  logic            iStall,
   input  ex_mem_t         iEX,
   output mem_wb_t         oWB,
   output logic            oStall,
   output logic            oDReq,
   output logic            oDWe,
   output logic [XLEN-1:0] oDAddr,
   output logic [XLEN-1:0] oDWData,
   output logic [3:0]      oDBe,
   input  logic            iDAck,
   input  logic [XLEN-1:0] iDRData
);
   mem_state_e      state_q, state_d;
   logic            req_q, req_d, we_q, we_d, regwr_q, regwr_d;
   logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d, pc_q, pc_d, hold_q, hold_d;
   logic [3:0]      be_q, be_d;
   logic [2:0]      f3_q, f3_d;
   logic [1:0]      off_q, off_d;
   logic [4:0]      rd_q, rd_d;
   mem_wb_t         wb_q, wb_d, fin_wb;

   logic            mem_op, is_load, is_store, legal, op_ok, can_retire;
   logic [XLEN-1:0] st_wdata, ld_data, fin_data;
   logic [3:0]      st_be;

   assign mem_op     = iEX.valid & (iEX.mem_read | iEX.mem_write);
   assign is_store   = iEX.mem_write;
   assign is_load    = iEX.mem_read & ~iEX.mem_write;
   assign op_ok      = mem_op & legal;
   assign can_retire = iEn & ~iStall;

   mem_align u_align (
      .is_load_i   (is_load),
      .is_store_i  (is_store),
      .funct3_i    (iEX.funct3),
      .off_i       (iEX.alu_result[1:0]),
      .st_data_i   (iEX.rs2_data),
      .legal_o     (legal),
      .st_wdata_o  (st_wdata),
      .be_o        (st_be),
      .ld_funct3_i (f3_q),
      .ld_off_i    (off_q),
      .rdata_i     (iDRData),
      .ld_data_o   (ld_data)
   );

   // Stores report their full effective address as the writeback value.
   assign fin_data = we_q ? {addr_q[XLEN-1:2], off_q} : ld_data;

   always_comb begin
      fin_wb           = '0;
      fin_wb.valid     = 1'b1;
      fin_wb.pc        = pc_q;
      fin_wb.rd        = rd_q;
      fin_wb.reg_write = regwr_q & ~we_q;
      fin_wb.wb_data   = (state_q == ST_DONE) ? hold_q : fin_data;
   end

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      f3_d    = f3_q;
      off_d   = off_q;
      rd_d    = rd_q;
      pc_d    = pc_q;
      regwr_d = regwr_q;
      hold_d  = hold_q;
      wb_d    = wb_q;
      case (state_q)
         ST_IDLE: begin
            if (iEn && op_ok) begin
               state_d = ST_BUSY;
               req_d   = 1'b1;
               we_d    = is_store;
               addr_d  = {iEX.alu_result[XLEN-1:2], 2'b00};
               wdata_d = st_wdata;
               be_d    = is_store ? st_be : 4'b1111;
               f3_d    = iEX.funct3;
               off_d   = iEX.alu_result[1:0];
               rd_d    = iEX.rd;
               pc_d    = iEX.pc;
               regwr_d = iEX.reg_write;
               if (!iStall) wb_d.valid = 1'b0;
            end else if (can_retire) begin
               wb_d.valid     = iEX.valid;
               wb_d.pc        = iEX.pc;
               wb_d.rd        = iEX.rd;
               wb_d.reg_write = iEX.reg_write & ~mem_op;
               wb_d.wb_data   = iEX.alu_result;
               wb_d.fault     = mem_op;
            end
         end
         ST_BUSY: begin
            // The ack is taken even when disabled so it can never be dropped.
            if (iDAck) begin
               req_d = 1'b0;
               if (can_retire) begin
                  state_d = ST_IDLE;
                  wb_d    = fin_wb;
               end else begin
                  state_d = ST_DONE;
                  hold_d  = fin_data;
               end
            end else if (can_retire) begin
               wb_d.valid = 1'b0;
            end
         end
         ST_DONE: begin
            if (can_retire) begin
               state_d = ST_IDLE;
               wb_d    = fin_wb;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge iClk or negedge nRst) begin
      if (!nRst) begin
         state_q <= ST_IDLE;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         f3_q    <= '0;
         off_q   <= '0;
         rd_q    <= '0;
         pc_q    <= '0;
         regwr_q <= 1'b0;
         hold_q  <= '0;
         wb_q    <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         f3_q    <= f3_d;
         off_q   <= off_d;
         rd_q    <= rd_d;
         pc_q    <= pc_d;
         regwr_q <= regwr_d;
         hold_q  <= hold_d;
         wb_q    <= wb_d;
      end
   end

   assign oStall  = (state_q != ST_IDLE) | op_ok | iStall;
   assign oWB     = wb_q;
   assign oDReq   = req_q;
   assign oDWe    = we_q;
   assign oDAddr  = addr_q;
   assign oDWData = wdata_q;
   assign oDBe    = be_q;
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized loads/stores
// compared against an arithmetic model of the access rules.
module tb_mem_stage;
   import mem_stage_pkg::*;

   logic        clk = 1'b0;
   logic        nRst, iEn, iStall, iDAck;
   logic [31:0] iDRData;
   ex_mem_t     ex;
   mem_wb_t     oWB;
   logic        oStall, oDReq, oDWe;
   logic [31:0] oDAddr, oDWData;
   logic [3:0]  oDBe;
   int          checks = 0;
   int          errors = 0;

   typedef struct {
      logic        req0;
      logic [31:0] addr;
      logic [3:0]  be;
      logic        we;
      logic [31:0] wdata;
      logic        stall_issue;
      logic        req_after;
      bit          stable;
      bit          stall_ok;
      bit          wb_held;
      mem_wb_t     wb;
   } obs_t;

   always #5 clk = ~clk;

   mem_stage dut (
      .iClk(clk), .nRst(nRst), .iEn(iEn), .iStall(iStall), .iEX(ex), .oWB(oWB),
      .oStall(oStall), .oDReq(oDReq), .oDWe(oDWe), .oDAddr(oDAddr), .oDWData(oDWData),
      .oDBe(oDBe), .iDAck(iDAck), .iDRData(iDRData)
   );

   // ---------------- reference model ----------------
   function automatic int unsigned m_size(input logic [2:0] f3);
      return 32'd1 << f3[1:0];
   endfunction

   function automatic bit m_legal(input bit st, input logic [2:0] f3, input logic [31:0] a);
      bit known;
      known = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
      return known && (a % m_size(f3) == 0);
   endfunction

   function automatic logic [31:0] m_load(input logic [31:0] rdata, input logic [2:0] f3,
                                          input logic [31:0] a);
      longint unsigned v, span;
      span = 64'd1 << (8 * m_size(f3));
      v = (64'(rdata) >> (8 * (a % 4))) % span;
      if (f3 < 3'd4 && m_size(f3) < 4 && v >= span / 2) v = v - span;
      return v[31:0];
   endfunction

   function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
      logic [7:0] m;
      m = ((8'd1 << m_size(f3)) - 8'd1) << (a % 4);
      return m[3:0];
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
      if (m_size(f3) == 1) return (d % 256) * 32'h0101_0101;
      if (m_size(f3) == 2) return (d % 65536) * 32'h0001_0001;
      return d;
   endfunction

   // ---------------- stimulus driver ----------------
   task automatic run_mem(input bit st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input logic [4:0] rd, input logic [31:0] pc,
                          input logic [31:0] rdata, input int dly, input int hold,
                          output obs_t o);
      mem_wb_t snap;
      o = '{default: '0};
      o.stable = 1; o.stall_ok = 1; o.wb_held = 1;
      ex = '0;
      ex.valid = 1'b1; ex.pc = pc; ex.alu_result = a; ex.rs2_data = d; ex.rd = rd;
      ex.reg_write = !st; ex.mem_read = !st; ex.mem_write = st; ex.funct3 = f3;
      iStall = 1'b0; iDAck = 1'b0;
      #1 o.stall_issue = oStall;
      @(negedge clk);
      ex = '0;
      o.req0 = oDReq; o.addr = oDAddr; o.be = oDBe; o.we = oDWe; o.wdata = oDWData;
      if (!o.req0) begin
         o.wb = oWB;
         o.req_after = oDReq;
         return;
      end
      for (int k = 0; k <= dly; k++) begin
         if (k > 0) @(negedge clk);
         if (!oStall) o.stall_ok = 0;
         if ({oDReq, oDWe, oDAddr, oDWData, oDBe} !== {1'b1, o.we, o.addr, o.wdata, o.be})
            o.stable = 0;
      end
      snap = oWB;
      iDAck = 1'b1; iDRData = rdata; iStall = (hold > 0);
      #1 if (!oStall) o.stall_ok = 0;
      @(negedge clk);
      iDAck = 1'b0; iDRData = $urandom;
      o.req_after = oDReq;
      for (int h = 1; h < hold; h++) begin
         if (oWB !== snap) o.wb_held = 0;
         if (!oStall) o.stall_ok = 0;
         @(negedge clk);
      end
      if (hold > 0) begin
         if (oWB !== snap) o.wb_held = 0;
         if (!oStall) o.stall_ok = 0;
         iStall = 1'b0;
         @(negedge clk);
      end
      o.wb = oWB;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      checks++; if (oWB !== '0) begin errors++; $display("FAIL reset_wb: got %h want 0", oWB); end
      checks++; if ({oDReq, oDWe, oDBe} !== 6'd0) begin errors++; $display("FAIL reset_req: got %b want 0", {oDReq, oDWe, oDBe}); end
      checks++; if ({oDAddr, oDWData} !== 64'd0) begin errors++; $display("FAIL reset_bus: got %h want 0", {oDAddr, oDWData}); end
      nRst = 1'b1;
      @(negedge clk);
      checks++; if (oWB !== '0 || oDReq !== 1'b0 || oStall !== 1'b0) begin errors++; $display("FAIL reset_idle: got wb=%h req=%b stall=%b want zeros", oWB, oDReq, oStall); end
   endtask

   task automatic test_lb();
      obs_t o;
      run_mem(0, F3_LB, 32'h1003, 32'h0, 5'd7, 32'h100, 32'h80AA_BBCC, 0, 0, o);
      $display("txn lb addr=00001003 wb=%h", o.wb.wb_data);
      checks++; if (o.req0 !== 1'b1) begin errors++; $display("FAIL lb_req: got %b want 1", o.req0); end
      checks++; if (o.addr !== 32'h1000) begin errors++; $display("FAIL lb_addr: got %h want 00001000", o.addr); end
      checks++; if (o.be !== 4'b1111 || o.we !== 1'b0) begin errors++; $display("FAIL lb_be_we: got %b/%b want 1111/0", o.be, o.we); end
      checks++; if (o.wb.wb_data !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data: got %h want ffffff80", o.wb.wb_data); end
      checks++; if (o.wb.rd !== 5'd7 || o.wb.valid !== 1'b1 || o.wb.reg_write !== 1'b1) begin errors++; $display("FAIL lb_wb: got rd=%0d v=%b rw=%b want 7/1/1", o.wb.rd, o.wb.valid, o.wb.reg_write); end
      checks++; if (o.req_after !== 1'b0) begin errors++; $display("FAIL lb_req_drop: got %b want 0", o.req_after); end
   endtask

   task automatic test_sh();
      obs_t o;
      run_mem(1, F3_SH, 32'h2002, 32'h1234_ABCD, 5'd2, 32'h104, 32'h0, 1, 0, o);
      $display("txn sh addr=00002002 wdata=%h be=%b", o.wdata, o.be);
      checks++; if (o.wdata !== 32'hABCD_ABCD) begin errors++; $display("FAIL sh_wdata: got %h want abcdabcd", o.wdata); end
      checks++; if (o.be !== 4'b1100 || o.we !== 1'b1) begin errors++; $display("FAIL sh_be_we: got %b/%b want 1100/1", o.be, o.we); end
      checks++; if (o.addr !== 32'h2000 || !o.stable) begin errors++; $display("FAIL sh_addr: got %h stable=%0d want 00002000 stable=1", o.addr, o.stable); end
      checks++; if (o.wb.reg_write !== 1'b0 || o.wb.wb_data !== 32'h2002 || o.wb.valid !== 1'b1) begin errors++; $display("FAIL sh_wb: got rw=%b data=%h v=%b want 0/00002002/1", o.wb.reg_write, o.wb.wb_data, o.wb.valid); end
   endtask

   task automatic test_misaligned();
      obs_t o;
      run_mem(0, F3_LW, 32'h3001, 32'h0, 5'd4, 32'h108, 32'h0, 0, 0, o);
      $display("txn lw misaligned addr=00003001 fault=%b", o.wb.fault);
      checks++; if (o.req0 !== 1'b0 || o.stall_issue !== 1'b0) begin errors++; $display("FAIL mis_req: got req=%b stall=%b want 0/0", o.req0, o.stall_issue); end
      checks++; if (o.wb.fault !== 1'b1 || o.wb.reg_write !== 1'b0 || o.wb.valid !== 1'b1) begin errors++; $display("FAIL mis_wb: got f=%b rw=%b v=%b want 1/0/1", o.wb.fault, o.wb.reg_write, o.wb.valid); end
      @(negedge clk);
      checks++; if (oDReq !== 1'b0 || oStall !== 1'b0) begin errors++; $display("FAIL mis_after: got req=%b stall=%b want 0/0", oDReq, oStall); end
   endtask

   task automatic test_lhu_wait_hold();
      obs_t o;
      run_mem(0, F3_LHU, 32'h4002, 32'h0, 5'd11, 32'h10C, 32'hBEEF_1234, 3, 2, o);
      $display("txn lhu addr=00004002 wb=%h", o.wb.wb_data);
      checks++; if (!o.stall_ok || !o.stable) begin errors++; $display("FAIL lhu_stall: got stall_ok=%0d stable=%0d want 1/1", o.stall_ok, o.stable); end
      checks++; if (!o.wb_held) begin errors++; $display("FAIL lhu_hold: got held=%0d want 1", o.wb_held); end
      checks++; if (o.wb.wb_data !== 32'h0000_BEEF || o.wb.rd !== 5'd11) begin errors++; $display("FAIL lhu_data: got %h rd=%0d want 0000beef rd=11", o.wb.wb_data, o.wb.rd); end
   endtask

   task automatic test_alu_hold();
      mem_wb_t snap;
      ex = '0; ex.valid = 1'b1; ex.pc = 32'h700; ex.alu_result = 32'h55; ex.rd = 5'd3; ex.reg_write = 1'b1;
      iStall = 1'b1;
      snap = oWB;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++; if (oWB !== snap || oStall !== 1'b1) begin errors++; $display("FAIL alu_stall%0d: got wb=%h stall=%b want held/1", c, oWB, oStall); end
      end
      iStall = 1'b0;
      @(negedge clk);
      $display("txn alu add wb=%h", oWB.wb_data);
      checks++; if (oWB.wb_data !== 32'h55 || oWB.valid !== 1'b1 || oWB.rd !== 5'd3 || oWB.fault !== 1'b0) begin errors++; $display("FAIL alu_out: got %h v=%b rd=%0d want 00000055/1/3", oWB.wb_data, oWB.valid, oWB.rd); end
      iStall = 1'b1; ex.alu_result = 32'h66;
      snap = oWB;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         checks++; if (oWB !== snap) begin errors++; $display("FAIL alu_hold%0d: got %h want %h", c, oWB, snap); end
      end
      iStall = 1'b0;
      @(negedge clk);
      checks++; if (oWB.wb_data !== 32'h66) begin errors++; $display("FAIL alu_out2: got %h want 00000066", oWB.wb_data); end
      ex = '0;
      @(negedge clk);
   endtask

   task automatic test_enable();
      mem_wb_t snap;
      ex = '0; ex.valid = 1'b1; ex.pc = 32'h600; ex.alu_result = 32'h6004; ex.rd = 5'd9;
      ex.reg_write = 1'b1; ex.mem_read = 1'b1; ex.funct3 = F3_LW;
      @(negedge clk);
      ex = '0; iEn = 1'b0; snap = oWB; iDAck = 1'b1; iDRData = 32'hCAFE_F00D;
      @(negedge clk);
      iDAck = 1'b0;
      checks++; if (oDReq !== 1'b0 || oWB !== snap) begin errors++; $display("FAIL en_ack: got req=%b wb=%h want 0/held", oDReq, oWB); end
      @(negedge clk);
      checks++; if (oWB !== snap) begin errors++; $display("FAIL en_hold: got %h want %h", oWB, snap); end
      iEn = 1'b1;
      @(negedge clk);
      $display("txn lw with enable low at ack wb=%h", oWB.wb_data);
      checks++; if (oWB.valid !== 1'b1 || oWB.wb_data !== 32'hCAFE_F00D || oWB.rd !== 5'd9) begin errors++; $display("FAIL en_out: got v=%b %h rd=%0d want 1/cafef00d/9", oWB.valid, oWB.wb_data, oWB.rd); end
   endtask

   task automatic test_random();
      obs_t        o;
      mem_wb_t     exp;
      bit          st, lg;
      logic [2:0]  f3;
      logic [31:0] a, d, rdata, pc;
      logic [4:0]  rd;
      int          k;
      for (int i = 0; i < 40; i++) begin
         st = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 4) == 0) f3 = 3'($urandom_range(0, 7));
         else if (st) f3 = 3'($urandom_range(0, 2));
         else begin k = $urandom_range(0, 4); f3 = (k < 3) ? 3'(k) : 3'(k + 1); end
         a = 32'h0001_0000 | ($urandom & 32'hFFFF);
         d = $urandom; rdata = $urandom; pc = $urandom & 32'hFFFC; rd = 5'($urandom_range(1, 31));
         if ($urandom_range(0, 4) == 0) begin
            ex = '0; ex.valid = 1'b1; ex.pc = pc; ex.alu_result = a; ex.rd = rd; ex.reg_write = 1'b1;
            @(negedge clk);
            ex = '0;
            $display("txn %0d alu wb=%h", i, oWB.wb_data);
            checks++; if (oWB.wb_data !== a || oWB.rd !== rd || oWB.valid !== 1'b1 || oDReq !== 1'b0) begin errors++; $display("FAIL rnd%0d_alu: got %h rd=%0d req=%b want %h rd=%0d", i, oWB.wb_data, oWB.rd, oDReq, a, rd); end
            continue;
         end
         lg = m_legal(st, f3, a);
         run_mem(st, f3, a, d, rd, pc, rdata, $urandom_range(0, 3), $urandom_range(0, 2), o);
         exp = '0; exp.valid = 1'b1; exp.pc = pc; exp.rd = rd;
         exp.reg_write = lg && !st; exp.fault = !lg;
         exp.wb_data = (!lg || st) ? a : m_load(rdata, f3, a);
         $display("txn %0d %s f3=%0d addr=%h legal=%0d wb=%h", i, st ? "store" : "load", f3, a, lg, o.wb.wb_data);
         checks++; if (o.req0 !== lg) begin errors++; $display("FAIL rnd%0d_req: got %b want %b", i, o.req0, lg); end
         checks++; if (o.wb !== exp) begin errors++; $display("FAIL rnd%0d_wb: got %h want %h", i, o.wb, exp); end
         if (lg) begin
            checks++; if (o.addr !== a - (a % 4) || o.we !== st) begin errors++; $display("FAIL rnd%0d_addr: got %h we=%b want %h we=%b", i, o.addr, o.we, a - (a % 4), st); end
            checks++; if (o.be !== (st ? m_be(f3, a) : 4'b1111)) begin errors++; $display("FAIL rnd%0d_be: got %b want %b", i, o.be, st ? m_be(f3, a) : 4'b1111); end
            if (st) begin
               checks++; if (o.wdata !== m_wdata(f3, d)) begin errors++; $display("FAIL rnd%0d_wdata: got %h want %h", i, o.wdata, m_wdata(f3, d)); end
            end
            checks++; if (!o.stable || !o.stall_ok || !o.wb_held || o.req_after !== 1'b0) begin errors++; $display("FAIL rnd%0d_hs: got stable=%0d stall=%0d held=%0d req=%b want 1/1/1/0", i, o.stable, o.stall_ok, o.wb_held, o.req_after); end
         end else begin
            checks++; if (o.stall_issue !== 1'b0) begin errors++; $display("FAIL rnd%0d_fstall: got %b want 0", i, o.stall_issue); end
         end
      end
   endtask

   task automatic test_reset_mid_busy();
      ex = '0; ex.valid = 1'b1; ex.pc = 32'h800; ex.alu_result = 32'h5000; ex.rd = 5'd6;
      ex.reg_write = 1'b1; ex.mem_read = 1'b1; ex.funct3 = F3_LW;
      @(negedge clk);
      ex = '0;
      checks++; if (oDReq !== 1'b1) begin errors++; $display("FAIL rst_busy: got req=%b want 1", oDReq); end
      #2 nRst = 1'b0;
      #1;
      checks++; if (oDReq !== 1'b0) begin errors++; $display("FAIL rst_async_req: got %b want 0", oDReq); end
      checks++; if (oWB !== '0 || {oDWe, oDBe, oDAddr, oDWData} !== '0) begin errors++; $display("FAIL rst_async_out: got wb=%h addr=%h want zeros", oWB, oDAddr); end
      @(negedge clk);
      nRst = 1'b1; iDAck = 1'b1; iDRData = 32'h1111_2222;
      $display("txn reset mid-busy then late ack");
      @(negedge clk);
      iDAck = 1'b0;
      for (int c = 0; c < 2; c++) begin
         checks++; if (oWB.valid !== 1'b0 || oDReq !== 1'b0 || oStall !== 1'b0) begin errors++; $display("FAIL rst_late_ack%0d: got v=%b req=%b stall=%b want 0/0/0", c, oWB.valid, oDReq, oStall); end
         @(negedge clk);
      end
   endtask

   initial begin
      nRst = 1'b0; iEn = 1'b1; iStall = 1'b0; iDAck = 1'b0; iDRData = '0; ex = '0;
      repeat (2) @(negedge clk);
      test_reset();
      test_lb();
      test_sh();
      test_misaligned();
      test_lhu_wait_hold();
      test_alu_hold();
      test_enable();
      test_random();
      test_reset_mid_busy();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
